psram_apb_arbiter: RTL and testbench
====================================

# psram_apb_arbiter

Two-requester APB arbiter that shares the single PSRAM APB slave port (the QSPI PSRAM controller wrapper) between requester 0 (CPU LSU) and requester 1 (DMA/IFU). It selects one pending requester, replays its transfer on the slave side as a registered SETUP/ACCESS sequence, and returns PREADY/PRDATA/PSLVERR only to the granted requester. Selection is round-robin or fixed-priority.

## Interface
- RR, default 1: 1 = round-robin on ties; 0 = fixed priority, requester 0 always wins.
- clock  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in0_paddr, in1_paddr  input  32  requester address.
- in0_psel, in0_penable, in0_pwrite, in1_psel, in1_penable, in1_pwrite  input  1 each  requester APB controls.
- in0_pprot, in1_pprot  input  3  protection bits.
- in0_pwdata, in1_pwdata  input  32  write data.
- in0_pstrb, in1_pstrb  input  4  byte strobes.
- in0_pready, in1_pready  output  1 each  completion to the requester.
- in0_prdata, in1_prdata  output  32  read data to the requester.
- in0_pslverr, in1_pslverr  output  1 each  error to the requester.
- out_paddr, out_pwdata  output  32  registered address/write data to the slave.
- out_pstrb  output  4; out_pprot  output  3; out_pwrite, out_psel, out_penable  output  1  registered slave controls.
- out_pready, out_pslverr  input  1  slave response.
- out_prdata  input  32  slave read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS. Registers: state, grant (1 bit), last (1 bit), and out_* request fields.
- IDLE: a requester is pending when its inN_psel=1. If none is pending, stay in IDLE. If only one is pending, grant it. If both are pending and RR=1, grant !last; if RR=0, grant 0. On a grant: set grant, latch the grantee's paddr/pwdata/pstrb/pprot/pwrite into the out_* registers, and go to SETUP.
- SETUP: out_psel=1, out_penable=0. Go to ACCESS unconditionally.
- ACCESS: out_psel=1, out_penable=1. Hold until out_pready=1. In that cycle:
  - in[grant]_pready=out_pready, combinationally.
  - in[grant]_prdata=out_prdata and in[grant]_pslverr=out_pslverr, combinationally.
  - Set last=grant and go to IDLE.
- The non-granted requester always sees pready=0, prdata=0, pslverr=0. The granted requester sees the same values outside the completing ACCESS cycle.
- Requester requests are never forwarded combinationally. The out_* request fields change only on the IDLE→SETUP edge.
- Protocol violation (granted requester drops psel before its pready): the slave transfer still completes, and the response is discarded. The arbiter returns to IDLE normally.
- out_pslverr is passed through unmodified. The arbiter never generates errors.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, grant=0, last=1 (the first tie goes to requester 0).
  - out_psel=0, out_penable=0, out_pwrite=0, out_paddr=0, out_pwdata=0, out_pstrb=0, out_pprot=0.
  - All inN_pready, inN_prdata and inN_pslverr = 0.
- Reset asserted mid-transfer: out_psel drops in the same cycle, and no response is delivered.
- Latency: requester psel high in IDLE at cycle T gives out_psel=1 at T+1, out_penable=1 at T+2, and earliest inN_pready=1 at T+2. A zero-wait slave therefore gives 3 cycles from request to pready.
- Slave wait states extend ACCESS one cycle each. The out_* fields are stable throughout.
- After completion at cycle C, the state is IDLE at C+1. A new request (from either requester) sampled at C+1 gives out_psel at C+2. There is one mandatory idle cycle between slave transfers.
- Simultaneous requests: exactly one grant per IDLE cycle. The loser keeps psel asserted and is served next; with RR=1 it is guaranteed the next grant.
- A request arriving while the FSM is busy waits; nothing is queued beyond the requester holding psel.

## Test plan
- Single read: in0 read, paddr=0x8000_0010, slave returns 0xDEAD_BEEF with 2 wait states -> out_psel at T+1, out_penable at T+2, in0_pready=1 at T+4 with in0_prdata=0xDEAD_BEEF; in1_pready stays 0 throughout.
- Tie, RR=1: both request at once after reset -> in0 served first, then in1 (out_paddr switches to in1's address at the next IDLE→SETUP). Repeating the tie alternates 1,0,1,...
- Fixed priority, RR=0: in0 issues back-to-back writes while in1 holds psel -> in1 starves until in0 idles one cycle, then in1 completes.
- Write path: in1 write, pwdata=0x1234_5678, pstrb=0b0011 -> out_pwrite=1, out_pwdata=0x1234_5678, out_pstrb=0b0011 are stable from SETUP through pready; in1_pslverr=0.
- Error pass-through: slave returns out_pslverr=1 -> granted requester sees pslverr=1 with pready; the other requester sees 0.
- Reset in ACCESS: assert reset while out_penable=1 -> out_psel=0 and out_penable=0 immediately; after release, the next tie grants requester 0.

Source files
------------

// File: rtl/psram_apb_arbiter.sv
// rtl/psram_apb_arbiter.sv - two-requester APB arbiter in front of the PSRAM controller slave port
module psram_apb_arbiter #(
    parameter bit RR = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in0_paddr,
    input  logic        in0_psel,
    input  logic        in0_penable,
    input  logic        in0_pwrite,
    input  logic [2:0]  in0_pprot,
    input  logic [31:0] in0_pwdata,
    input  logic [3:0]  in0_pstrb,
    output logic        in0_pready,
    output logic [31:0] in0_prdata,
    output logic        in0_pslverr,
    input  logic [31:0] in1_paddr,
    input  logic        in1_psel,
    input  logic        in1_penable,
    input  logic        in1_pwrite,
    input  logic [2:0]  in1_pprot,
    input  logic [31:0] in1_pwdata,
    input  logic [3:0]  in1_pstrb,
    output logic        in1_pready,
    output logic [31:0] in1_prdata,
    output logic        in1_pslverr,
    output logic [31:0] out_paddr,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    output logic [2:0]  out_pprot,
    output logic        out_pwrite,
    output logic        out_psel,
    output logic        out_penable,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t state;
    logic   grant;
    logic   last;
    logic   pick;
    logic   done;
    logic   done0;
    logic   done1;

    // Requester phase is irrelevant here: a pending transfer is defined by psel alone.
    logic unused_penable;
    assign unused_penable = in0_penable ^ in1_penable;

    always_comb begin
        pick = 1'b0;
        if (in0_psel && in1_psel)
            pick = RR ? ~last : 1'b0;
        else if (in1_psel)
            pick = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last        <= 1'b1;
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            out_pwrite  <= 1'b0;
            out_paddr   <= '0;
            out_pwdata  <= '0;
            out_pstrb   <= '0;
            out_pprot   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in0_psel || in1_psel) begin
                        grant       <= pick;
                        out_paddr   <= pick ? in1_paddr  : in0_paddr;
                        out_pwdata  <= pick ? in1_pwdata : in0_pwdata;
                        out_pstrb   <= pick ? in1_pstrb  : in0_pstrb;
                        out_pprot   <= pick ? in1_pprot  : in0_pprot;
                        out_pwrite  <= pick ? in1_pwrite : in0_pwrite;
                        out_psel    <= 1'b1;
                        out_penable <= 1'b0;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    out_penable <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (out_pready) begin
                        last        <= grant;
                        out_psel    <= 1'b0;
                        out_penable <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A grantee that dropped psel mid-transfer gets nothing back; the slave cycle still finishes.
    assign done  = (state == ACCESS) && out_pready;
    assign done0 = done && !grant && in0_psel;
    assign done1 = done &&  grant && in1_psel;

    assign in0_pready  = done0;
    assign in0_prdata  = done0 ? out_prdata : '0;
    assign in0_pslverr = done0 & out_pslverr;
    assign in1_pready  = done1;
    assign in1_prdata  = done1 ? out_prdata : '0;
    assign in1_pslverr = done1 & out_pslverr;

endmodule

// File: tb/tb_psram_apb_arbiter.sv
// tb/tb_psram_apb_arbiter.sv - cycle-table and directed-sequence bench for psram_apb_arbiter
module tb_psram_apb_arbiter;

    localparam logic [31:0] A0 = 32'h8000_0010;
    localparam logic [31:0] A1 = 32'h4000_0020;
    localparam logic [31:0] Z  = 32'h0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in0_paddr = A0, in1_paddr = A1;
    logic        in0_psel = 1'b0, in1_psel = 1'b0;
    logic        in0_pwrite = 1'b0, in1_pwrite = 1'b1;
    logic [2:0]  in0_pprot = 3'b010, in1_pprot = 3'b101;
    logic [31:0] in0_pwdata = 32'hAAAA_5555, in1_pwdata = 32'h1234_5678;
    logic [3:0]  in0_pstrb = 4'b1111, in1_pstrb = 4'b0011;
    logic        slv_pready = 1'b0, slv_pslverr = 1'b0;
    logic [31:0] slv_prdata = '0;

    logic        rr_in0_pready, rr_in0_pslverr, rr_in1_pready, rr_in1_pslverr;
    logic [31:0] rr_in0_prdata, rr_in1_prdata, rr_paddr, rr_pwdata;
    logic [3:0]  rr_pstrb;
    logic [2:0]  rr_pprot;
    logic        rr_pwrite, rr_psel, rr_penable;

    logic        fp_in0_pready, fp_in0_pslverr, fp_in1_pready, fp_in1_pslverr;
    logic [31:0] fp_in0_prdata, fp_in1_prdata, fp_paddr, fp_pwdata;
    logic [3:0]  fp_pstrb;
    logic [2:0]  fp_pprot;
    logic        fp_pwrite, fp_psel, fp_penable;

    always #5 clock = ~clock;

    psram_apb_arbiter #(.RR(1'b1)) u_rr (
        .clock(clock), .reset(reset),
        .in0_paddr(in0_paddr), .in0_psel(in0_psel), .in0_penable(in0_psel), .in0_pwrite(in0_pwrite),
        .in0_pprot(in0_pprot), .in0_pwdata(in0_pwdata), .in0_pstrb(in0_pstrb),
        .in0_pready(rr_in0_pready), .in0_prdata(rr_in0_prdata), .in0_pslverr(rr_in0_pslverr),
        .in1_paddr(in1_paddr), .in1_psel(in1_psel), .in1_penable(in1_psel), .in1_pwrite(in1_pwrite),
        .in1_pprot(in1_pprot), .in1_pwdata(in1_pwdata), .in1_pstrb(in1_pstrb),
        .in1_pready(rr_in1_pready), .in1_prdata(rr_in1_prdata), .in1_pslverr(rr_in1_pslverr),
        .out_paddr(rr_paddr), .out_pwdata(rr_pwdata), .out_pstrb(rr_pstrb), .out_pprot(rr_pprot),
        .out_pwrite(rr_pwrite), .out_psel(rr_psel), .out_penable(rr_penable),
        .out_pready(slv_pready), .out_prdata(slv_prdata), .out_pslverr(slv_pslverr)
    );

    psram_apb_arbiter #(.RR(1'b0)) u_fp (
        .clock(clock), .reset(reset),
        .in0_paddr(in0_paddr), .in0_psel(in0_psel), .in0_penable(in0_psel), .in0_pwrite(in0_pwrite),
        .in0_pprot(in0_pprot), .in0_pwdata(in0_pwdata), .in0_pstrb(in0_pstrb),
        .in0_pready(fp_in0_pready), .in0_prdata(fp_in0_prdata), .in0_pslverr(fp_in0_pslverr),
        .in1_paddr(in1_paddr), .in1_psel(in1_psel), .in1_penable(in1_psel), .in1_pwrite(in1_pwrite),
        .in1_pprot(in1_pprot), .in1_pwdata(in1_pwdata), .in1_pstrb(in1_pstrb),
        .in1_pready(fp_in1_pready), .in1_prdata(fp_in1_prdata), .in1_pslverr(fp_in1_pslverr),
        .out_paddr(fp_paddr), .out_pwdata(fp_pwdata), .out_pstrb(fp_pstrb), .out_pprot(fp_pprot),
        .out_pwrite(fp_pwrite), .out_psel(fp_psel), .out_penable(fp_penable),
        .out_pready(slv_pready), .out_prdata(slv_prdata), .out_pslverr(slv_pslverr)
    );

    typedef struct {
        logic        rst, p0, p1, spr;
        logic [31:0] srd;
        logic        serr;
        logic        opsel, open;
        logic [31:0] oaddr;
        logic        r0, r1;
        logic [31:0] d0, d1;
        logic        e0, e1;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t v(input logic rst, p0, p1, spr, input logic [31:0] srd, input logic serr,
                               input logic opsel, open, input logic [31:0] oaddr,
                               input logic r0, r1, input logic [31:0] d0, d1, input logic e0, e1);
        vec_t t;
        t.rst = rst; t.p0 = p0; t.p1 = p1; t.spr = spr; t.srd = srd; t.serr = serr;
        t.opsel = opsel; t.open = open; t.oaddr = oaddr;
        t.r0 = r0; t.r1 = r1; t.d0 = d0; t.d1 = d1; t.e0 = e0; t.e1 = e1;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // reset, then in0 read with two wait states
        tbl.push_back(v(1,0,0,0,Z,0,            0,0,Z,  0,0,Z,Z,0,0));
        tbl.push_back(v(0,1,0,0,Z,0,            0,0,Z,  0,0,Z,Z,0,0));
        tbl.push_back(v(0,1,0,0,Z,0,            1,0,A0, 0,0,Z,Z,0,0));
        tbl.push_back(v(0,1,0,0,32'hDEADBEEF,0, 1,1,A0, 0,0,Z,Z,0,0));
        tbl.push_back(v(0,1,0,0,32'hDEADBEEF,0, 1,1,A0, 0,0,Z,Z,0,0));
        tbl.push_back(v(0,1,0,1,32'hDEADBEEF,0, 1,1,A0, 1,0,32'hDEADBEEF,Z,0,0));
        tbl.push_back(v(0,0,0,0,Z,0,            0,0,A0, 0,0,Z,Z,0,0));
        // round-robin ties alternate 0,1,0,1 with error pass-through
        tbl.push_back(v(1,0,0,0,Z,0,            0,0,Z,  0,0,Z,Z,0,0));
        tbl.push_back(v(0,1,1,0,Z,0,            0,0,Z,  0,0,Z,Z,0,0));
        tbl.push_back(v(0,1,1,0,Z,0,            1,0,A0, 0,0,Z,Z,0,0));
        tbl.push_back(v(0,1,1,1,32'h11111111,1, 1,1,A0, 1,0,32'h11111111,Z,1,0));
        tbl.push_back(v(0,1,1,0,Z,0,            0,0,A0, 0,0,Z,Z,0,0));
        tbl.push_back(v(0,1,1,0,Z,0,            1,0,A1, 0,0,Z,Z,0,0));
        tbl.push_back(v(0,1,1,1,32'h22222222,0, 1,1,A1, 0,1,Z,32'h22222222,0,0));
        tbl.push_back(v(0,1,1,0,Z,0,            0,0,A1, 0,0,Z,Z,0,0));
        tbl.push_back(v(0,1,1,0,Z,0,            1,0,A0, 0,0,Z,Z,0,0));
        tbl.push_back(v(0,1,1,1,32'h33333333,1, 1,1,A0, 1,0,32'h33333333,Z,1,0));
        tbl.push_back(v(0,1,1,0,Z,0,            0,0,A0, 0,0,Z,Z,0,0));
        tbl.push_back(v(0,1,1,0,Z,0,            1,0,A1, 0,0,Z,Z,0,0));
        tbl.push_back(v(0,1,1,1,32'h44444444,1, 1,1,A1, 0,1,Z,32'h44444444,0,1));
        tbl.push_back(v(0,0,0,0,Z,0,            0,0,A1, 0,0,Z,Z,0,0));
        // reset during ACCESS, then the next tie goes to in0
        tbl.push_back(v(1,0,0,0,Z,0,            0,0,Z,  0,0,Z,Z,0,0));
        tbl.push_back(v(0,0,1,0,Z,0,            0,0,Z,  0,0,Z,Z,0,0));
        tbl.push_back(v(0,0,1,0,Z,0,            1,0,A1, 0,0,Z,Z,0,0));
        tbl.push_back(v(0,0,1,0,Z,0,            1,1,A1, 0,0,Z,Z,0,0));
        tbl.push_back(v(1,0,1,1,32'h55555555,0, 0,0,Z,  0,0,Z,Z,0,0));
        tbl.push_back(v(0,1,1,0,Z,0,            0,0,Z,  0,0,Z,Z,0,0));
        tbl.push_back(v(0,1,1,0,Z,0,            1,0,A0, 0,0,Z,Z,0,0));
        tbl.push_back(v(0,1,1,1,32'h77777777,0, 1,1,A0, 1,0,32'h77777777,Z,0,0));
        tbl.push_back(v(0,0,0,0,Z,0,            0,0,A0, 0,0,Z,Z,0,0));
        // in1 drops psel before pready: response discarded, FSM still returns to IDLE
        tbl.push_back(v(0,0,1,0,Z,0,            0,0,A0, 0,0,Z,Z,0,0));
        tbl.push_back(v(0,0,1,0,Z,0,            1,0,A1, 0,0,Z,Z,0,0));
        tbl.push_back(v(0,0,0,1,32'h66666666,0, 1,1,A1, 0,0,Z,Z,0,0));
        tbl.push_back(v(0,0,0,0,Z,0,            0,0,A1, 0,0,Z,Z,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            reset = tbl[i].rst; in0_psel = tbl[i].p0; in1_psel = tbl[i].p1;
            slv_pready = tbl[i].spr; slv_prdata = tbl[i].srd; slv_pslverr = tbl[i].serr;
            #2;
            chk("out_psel",    i, {31'b0, rr_psel},        {31'b0, tbl[i].opsel});
            chk("out_penable", i, {31'b0, rr_penable},     {31'b0, tbl[i].open});
            chk("out_paddr",   i, rr_paddr,                tbl[i].oaddr);
            chk("in0_pready",  i, {31'b0, rr_in0_pready},  {31'b0, tbl[i].r0});
            chk("in1_pready",  i, {31'b0, rr_in1_pready},  {31'b0, tbl[i].r1});
            chk("in0_prdata",  i, rr_in0_prdata,           tbl[i].d0);
            chk("in1_prdata",  i, rr_in1_prdata,           tbl[i].d1);
            chk("in0_pslverr", i, {31'b0, rr_in0_pslverr}, {31'b0, tbl[i].e0});
            chk("in1_pslverr", i, {31'b0, rr_in1_pslverr}, {31'b0, tbl[i].e1});
        end

        // in1 write, two wait states: request fields stable from SETUP through pready
        @(negedge clock);
        reset = 1'b1; in0_psel = 1'b0; in1_psel = 1'b0; slv_pready = 1'b0; slv_prdata = '0; slv_pslverr = 1'b0;
        @(negedge clock);
        reset = 1'b0; in1_psel = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            slv_pready = (c == 4);
            #2;
            chk("wr_psel",    c, {31'b0, rr_psel},    32'd1);
            chk("wr_penable", c, {31'b0, rr_penable}, {31'b0, c != 1});
            chk("wr_pwrite",  c, {31'b0, rr_pwrite},  32'd1);
            chk("wr_pwdata",  c, rr_pwdata,           32'h1234_5678);
            chk("wr_pstrb",   c, {28'b0, rr_pstrb},   32'h3);
            chk("wr_pprot",   c, {29'b0, rr_pprot},   32'h5);
            chk("wr_pready",  c, {31'b0, rr_in1_pready}, {31'b0, c == 4});
            chk("wr_pslverr", c, {31'b0, rr_in1_pslverr}, 32'd0);
            chk("wr_in0_rdy", c, {31'b0, rr_in0_pready}, 32'd0);
        end
        @(negedge clock);
        in1_psel = 1'b0; slv_pready = 1'b0;
        #2;
        chk("wr_idle_psel", 0, {31'b0, rr_psel}, 32'd0);

        // fixed priority: in0 back-to-back starves in1 until in0 idles one cycle
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; slv_pready = 1'b1; slv_prdata = 32'hCAFE_0000;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clock);
            in0_psel = (c < 9);
            in1_psel = 1'b1;
            #2;
            if (c % 3 == 1)
                chk("fp_addr", c, fp_paddr, (c < 9) ? A0 : A1);
            chk("fp_in0_rdy", c, {31'b0, fp_in0_pready}, {31'b0, (c % 3 == 2) && (c < 9)});
            chk("fp_in1_rdy", c, {31'b0, fp_in1_pready}, {31'b0, c == 11});
        end
        @(negedge clock);
        in0_psel = 1'b0; in1_psel = 1'b0; slv_pready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
